seg_scan_decoder: RTL and testbench

//  Passive decoder for the multiplexed 7-segment bus that the stopwatch display logic drives.

---
 rtl/seg_scan_decoder.sv | 198 +++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Passive decoder for a multiplexed active-low 7-segment bus: qualifies stable scan slots,
// inverts segment patterns back to BCD and publishes complete 6-digit frames.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sseg,
  input  logic [5:0]  en,
  output logic [23:0] frame_digits,
  output logic [5:0]  frame_dp,
  output logic        frame_valid,
  output logic        frame_strobe,
  output logic        pattern_err,
  output logic        enable_err
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_QUAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  // Returns {valid, bcd}; anything outside the ten digit glyphs is invalid.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = {1'b1, 4'd0};
      7'h79:   seg_decode = {1'b1, 4'd1};
      7'h24:   seg_decode = {1'b1, 4'd2};
      7'h30:   seg_decode = {1'b1, 4'd3};
      7'h19:   seg_decode = {1'b1, 4'd4};
      7'h12:   seg_decode = {1'b1, 4'd5};
      7'h02:   seg_decode = {1'b1, 4'd6};
      7'h78:   seg_decode = {1'b1, 4'd7};
      7'h00:   seg_decode = {1'b1, 4'd8};
      7'h10:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  logic [SYNC_STAGES-1:0][7:0] sseg_sync_q, sseg_sync_d;
  logic [SYNC_STAGES-1:0][5:0] en_sync_q, en_sync_d;
  logic [13:0]      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [23:0]      shadow_q, shadow_d;
  logic [5:0]       shadow_dp_q, shadow_dp_d;
  logic [5:0]       mask_q, mask_d;
  logic [23:0]      frame_digits_q, frame_digits_d;
  logic [5:0]       frame_dp_q, frame_dp_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_strobe_q, frame_strobe_d;
  logic             pattern_err_q, pattern_err_d;
  logic             enable_err_q, enable_err_d;

  logic [7:0]  s_sseg;
  logic [5:0]  s_en;
  logic [13:0] sample_s;
  logic [5:0]  en_low_s;
  logic [5:0]  cap_bit_s;
  logic [4:0]  dec_s;
  logic        qualify_s, one_low_s, multi_low_s, capture_s, publish_s;

  // Input synchronizer shift chains.
  always_comb begin
    sseg_sync_d = {sseg_sync_q[SYNC_STAGES-2:0], sseg};
    en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], en};
  end

  assign s_sseg = sseg_sync_q[SYNC_STAGES-1];
  assign s_en   = en_sync_q[SYNC_STAGES-1];

  // Stability counting, slot capture, publish and timeout.
  always_comb begin
    sample_s       = {s_en, s_sseg};
    prev_d         = sample_s;
    en_low_s       = ~s_en;
    dec_s          = seg_decode(s_sseg[6:0]);
    cap_bit_s      = 6'd0;
    shadow_d       = shadow_q;
    shadow_dp_d    = shadow_dp_q;
    frame_digits_d = frame_digits_q;
    frame_dp_d     = frame_dp_q;
    frame_valid_d  = frame_valid_q;
    frame_strobe_d = 1'b0;
    pattern_err_d  = 1'b0;
    enable_err_d   = 1'b0;

    if (sample_s != prev_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Fires on exactly one edge per stable period: the step into saturation.
    qualify_s   = (sample_s == prev_q) && (cnt_q == CNT_QUAL);
    one_low_s   = (en_low_s != 6'd0) && ((en_low_s & (en_low_s - 6'd1)) == 6'd0);
    multi_low_s = (en_low_s != 6'd0) && !one_low_s;

    if (qualify_s && one_low_s) begin
      if (dec_s[4]) begin
        cap_bit_s = en_low_s;
      end else begin
        pattern_err_d = 1'b1;
      end
    end else begin
      cap_bit_s = 6'd0;
    end

    if (qualify_s && multi_low_s) begin
      enable_err_d = 1'b1;
    end else begin
      enable_err_d = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      if (cap_bit_s[i]) begin
        shadow_d[4*i +: 4] = dec_s[3:0];
        shadow_dp_d[i]     = ~s_sseg[7];
      end else begin
        shadow_d[4*i +: 4] = shadow_q[4*i +: 4];
        shadow_dp_d[i]     = shadow_dp_q[i];
      end
    end

    capture_s = (cap_bit_s != 6'd0);
    publish_s = (mask_q == 6'h3F);

    if (capture_s) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end

    mask_d = (publish_s ? 6'd0 : mask_q) | cap_bit_s;

    // tmo_d can only equal TMO_MAX when nothing was captured, so capture wins.
    if (publish_s) begin
      frame_digits_d = shadow_q;
      frame_dp_d     = shadow_dp_q;
      frame_strobe_d = 1'b1;
      frame_valid_d  = 1'b1;
    end else if (tmo_d == TMO_MAX) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end
  end

  // State registers; synchronizers and history idle at the blank-bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg_sync_q    <= '1;
      en_sync_q      <= '1;
      prev_q         <= '1;
      cnt_q          <= '0;
      tmo_q          <= '0;
      shadow_q       <= 24'd0;
      shadow_dp_q    <= 6'd0;
      mask_q         <= 6'd0;
      frame_digits_q <= 24'd0;
      frame_dp_q     <= 6'd0;
      frame_valid_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
      pattern_err_q  <= 1'b0;
      enable_err_q   <= 1'b0;
    end else begin
      sseg_sync_q    <= sseg_sync_d;
      en_sync_q      <= en_sync_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      shadow_q       <= shadow_d;
      shadow_dp_q    <= shadow_dp_d;
      mask_q         <= mask_d;
      frame_digits_q <= frame_digits_d;
      frame_dp_q     <= frame_dp_d;
      frame_valid_q  <= frame_valid_d;
      frame_strobe_q <= frame_strobe_d;
      pattern_err_q  <= pattern_err_d;
      enable_err_q   <= enable_err_d;
    end
  end

  assign frame_digits = frame_digits_q;
  assign frame_dp     = frame_dp_q;
  assign frame_valid  = frame_valid_q;
  assign frame_strobe = frame_strobe_q;
  assign pattern_err  = pattern_err_q;
  assign enable_err   = enable_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sseg;
  logic [5:0]  en;
  logic [23:0] frame_digits;
  logic [5:0]  frame_dp;
  logic        frame_valid, frame_strobe, pattern_err, enable_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_strobe, n_perr, n_eerr;
  int last_strobe_cyc = 0;
  int fall_cyc        = -1;
  logic prev_valid    = 1'b0;

  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sseg(sseg), .en(en),
    .frame_digits(frame_digits), .frame_dp(frame_dp), .frame_valid(frame_valid),
    .frame_strobe(frame_strobe), .pattern_err(pattern_err), .enable_err(enable_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (frame_strobe) begin
        n_strobe++;
        last_strobe_cyc = cyc;
      end
      if (pattern_err) n_perr++;
      if (enable_err) n_eerr++;
      if (prev_valid && !frame_valid) fall_cyc = cyc;
      prev_valid = frame_valid;
    end
  endtask

  task automatic clear_counts();
    n_strobe = 0;
    n_perr   = 0;
    n_eerr   = 0;
  endtask

  task automatic slot(input int i, input int d, input logic dp, input int n);
    en   = ~(6'd1 << i);
    sseg = {~dp, SEG[d]};
    tick(n);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_digits"}, {8'd0, frame_digits}, 32'h0);
    check({tag, "_dp"}, {26'd0, frame_dp}, 32'h0);
    check({tag, "_flags"}, {28'd0, frame_valid, frame_strobe, pattern_err, enable_err}, 32'h0);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 6'h3F;
    sseg = 8'hFF;
    clear_counts();
    tick(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    tick(5);

    // Test 1: full scan 6,5,4,3,2,1 with DP on slots 0,2,4.
    clear_counts();
    for (int i = 0; i < 5; i++) slot(i, 6 - i, (i % 2) == 0, 8);
    check("t1_no_early_strobe", n_strobe, 0);
    slot(5, 1, 1'b0, 8);
    check("t1_strobes", n_strobe, 1);
    check("t1_digits", {8'd0, frame_digits}, 32'h123456);
    check("t1_dp", {26'd0, frame_dp}, 32'h15);
    check("t1_valid", {31'd0, frame_valid}, 32'h1);
    check("t1_errs", n_perr + n_eerr, 0);

    // Test 5: frozen bus, frame_valid drops 64 cycles after the last capture.
    tick(70);
    check("t5_fall_delay", fall_cyc - last_strobe_cyc, 63);
    check("t5_valid", {31'd0, frame_valid}, 32'h0);
    check("t5_digits_hold", {8'd0, frame_digits}, 32'h123456);
    check("t5_dp_hold", {26'd0, frame_dp}, 32'h15);
    check("t5_strobes", n_strobe, 1);

    // Test 2: 3-cycle glitch is ignored, 4+ cycles capture.
    clear_counts();
    en   = 6'b111110;
    sseg = 8'hC0;
    tick(3);
    sseg = 8'hF9;
    tick(8);
    slot(1, 7, 1'b0, 8);
    slot(2, 8, 1'b0, 8);
    slot(3, 9, 1'b0, 8);
    slot(4, 0, 1'b0, 8);
    slot(5, 2, 1'b0, 3);
    en   = 6'h3F;
    sseg = 8'hFF;
    tick(10);
    check("t2_glitch_no_strobe", n_strobe, 0);
    slot(5, 2, 1'b0, 8);
    check("t2_strobes", n_strobe, 1);
    check("t2_digits", {8'd0, frame_digits}, 32'h209871);
    check("t2_dp", {26'd0, frame_dp}, 32'h0);
    check("t2_valid", {31'd0, frame_valid}, 32'h1);

    // Test 3: non-digit pattern on slot 0.
    clear_counts();
    en   = 6'b111110;
    sseg = 8'hFF;
    tick(10);
    check("t3_perr", n_perr, 1);
    check("t3_eerr", n_eerr, 0);
    check("t3_digits_hold", {8'd0, frame_digits}, 32'h209871);
    for (int i = 1; i < 6; i++) slot(i, i + 2, 1'b0, 8);
    check("t3_mask0_clear", n_strobe, 0);
    slot(0, 9, 1'b1, 8);
    check("t3_strobes", n_strobe, 1);
    check("t3_digits", {8'd0, frame_digits}, 32'h765439);
    check("t3_dp", {26'd0, frame_dp}, 32'h01);

    // Test 4: two enables low, then blank bus.
    clear_counts();
    en   = 6'b111100;
    sseg = {1'b1, SEG[3]};
    tick(10);
    check("t4_eerr", n_eerr, 1);
    check("t4_perr", n_perr, 0);
    en   = 6'h3F;
    sseg = 8'hFF;
    tick(10);
    check("t4_blank_eerr", n_eerr, 1);
    check("t4_blank_perr", n_perr, 0);
    check("t4_strobes", n_strobe, 0);

    // Test 6: reset mid-frame discards the partial mask and published data.
    clear_counts();
    slot(0, 1, 1'b0, 8);
    slot(1, 2, 1'b0, 8);
    slot(2, 3, 1'b0, 8);
    check("t6_valid_before", {31'd0, frame_valid}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("t6_async");
    tick(3);
    check_zero_outputs("t6_held");
    en   = 6'h3F;
    sseg = 8'hFF;
    rst  = 1'b0;
    clear_counts();
    slot(3, 4, 1'b0, 8);
    slot(4, 5, 1'b1, 8);
    slot(5, 6, 1'b0, 8);
    check("t6_no_strobe", n_strobe, 0);
    check("t6_valid_low", {31'd0, frame_valid}, 32'h0);
    check("t6_digits_zero", {8'd0, frame_digits}, 32'h0);
    slot(0, 1, 1'b0, 8);
    slot(1, 2, 1'b0, 8);
    slot(2, 3, 1'b0, 8);
    check("t6_strobes", n_strobe, 1);
    check("t6_digits", {8'd0, frame_digits}, 32'h654321);
    check("t6_dp", {26'd0, frame_dp}, 32'h10);
    check("t6_valid", {31'd0, frame_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
